// File: rtl/store_sequencer.sv
// store_sequencer: decodes a store request (width, byte lanes, strobes), then
// issues one or two aligned 32-bit write transactions on a valid/ready bus.
// Word-crossing stores are split into two writes or rejected with err,
// selected by SPLIT_MISALIGNED.
module store_sequencer #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_in,
  input  logic        amo_data_store,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;

  // Latched request: first word address, 64-bit lane window, 8 strobes.
  logic [29:0] word_q;
  logic [63:0] data_q;
  logic [7:0]  strb_q;
  logic        err_q;

  logic [3:0]  base_strb;
  logic        illegal;
  logic [63:0] wide_data;
  logic [7:0]  wide_strb;
  logic        split;
  logic        reject;

  // Width decode and lane alignment of the incoming request.
  always_comb begin
    base_strb = '0;
    illegal   = 1'b0;
    if (amo_data_store) begin
      base_strb = 4'b1111;
    end else begin
      case (funct3)
        3'b000:  base_strb = 4'b0001;
        3'b001:  base_strb = 4'b0011;
        3'b010:  base_strb = 4'b1111;
        default: illegal   = 1'b1;
      endcase
    end
    wide_data = {32'b0, wdata_in} << {addr[1:0], 3'b000};
    wide_strb = {4'b0, base_strb} << addr[1:0];
    split     = |wide_strb[7:4];
    reject    = illegal | (split & ~SPLIT_MISALIGNED);
  end

  // Next-state logic; request inputs only matter in IDLE, mem_ready only in ACCx.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) state_nx = reject ? RESP : ACC0;
      ACC0: if (mem_ready) state_nx = (|strb_q[7:4]) ? ACC1 : RESP;
      ACC1: if (mem_ready) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register; async reset abandons any in-flight store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Capture the aligned request on acceptance; held stable through ACC0/ACC1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      data_q <= '0;
      strb_q <= '0;
      err_q  <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      word_q <= addr[31:2];
      data_q <= wide_data;
      strb_q <= wide_strb;
      err_q  <= reject;
    end
  end

  // Outputs decoded from state and registered request only.
  always_comb begin
    req_ready = (state == IDLE);
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    done      = (state == RESP);
    err       = (state == RESP) & err_q;
    if (state == ACC0) begin
      mem_valid = 1'b1;
      mem_addr  = {word_q, 2'b00};
      mem_wdata = data_q[31:0];
      mem_wstrb = strb_q[3:0];
    end else if (state == ACC1) begin
      mem_valid = 1'b1;
      mem_addr  = {word_q + 30'd1, 2'b00};
      mem_wdata = data_q[63:32];
      mem_wstrb = strb_q[7:4];
    end
  end

endmodule
